// File: rtl/video_timing_gen.sv
// Raster timing generator: sync/blank decode, pixel request lookahead and a
// frame-synchronous reprogramming path. Optional colour-bar pattern: VTG_PATTERN_EN.
module video_timing_gen #(
    parameter int unsigned X_BITS   = 12,
    parameter int unsigned Y_BITS   = 12,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BACK   = 148,
    parameter int unsigned H_DISP   = 1920,
    parameter int unsigned H_FRONT  = 88,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BACK   = 36,
    parameter int unsigned V_DISP   = 1080,
    parameter int unsigned V_FRONT  = 4,
    parameter int unsigned V_TOTAL  = 1125,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned REQ_LEAD = 1
) (
    input  logic              pix_clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [11:0]       cfg_wdata,
    input  logic              cfg_apply,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [23:0]       video_data,
    output logic              frame_start,
    output logic              pix_req,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    input  logic [23:0]       pix_data,
    input  logic              pattern_en,
    output logic              cfg_busy
);

    typedef struct packed {
        logic [Y_BITS-1:0] v_total;
        logic [Y_BITS-1:0] v_front;
        logic [Y_BITS-1:0] v_disp;
        logic [Y_BITS-1:0] v_back;
        logic [Y_BITS-1:0] v_sync;
        logic [X_BITS-1:0] h_total;
        logic [X_BITS-1:0] h_front;
        logic [X_BITS-1:0] h_disp;
        logic [X_BITS-1:0] h_back;
        logic [X_BITS-1:0] h_sync;
    } timing_t;

    localparam timing_t TIMING_RST = '{
        v_total: Y_BITS'(V_TOTAL),
        v_front: Y_BITS'(V_FRONT),
        v_disp:  Y_BITS'(V_DISP),
        v_back:  Y_BITS'(V_BACK),
        v_sync:  Y_BITS'(V_SYNC),
        h_total: X_BITS'(H_TOTAL),
        h_front: X_BITS'(H_FRONT),
        h_disp:  X_BITS'(H_DISP),
        h_back:  X_BITS'(H_BACK),
        h_sync:  X_BITS'(H_SYNC)
    };

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    cfg_state_t        cfg_state;
    cfg_state_t        cfg_state_nxt;
    logic              commit;

    timing_t           act;
    timing_t           shd;
    timing_t           shd_nxt;

    logic [X_BITS-1:0] cnt_h;
    logic [Y_BITS-1:0] cnt_v;
    logic [X_BITS-1:0] h_last;
    logic [Y_BITS-1:0] v_last;
    logic              line_end;
    logic              frame_end;

    logic [X_BITS-1:0] h_start;
    logic [X_BITS-1:0] h_end;
    logic [Y_BITS-1:0] v_start;
    logic [Y_BITS-1:0] v_end;
    logic              cur_active;

    logic [X_BITS-1:0] h_sum;
    logic              ahead_wrap;
    logic [X_BITS-1:0] ah;
    logic [Y_BITS-1:0] av;
    logic              req_nxt;

    // Front porches are implied by the totals; the fields are stored but not decoded.
    logic              unused_front;
    assign unused_front = ^{act.h_front, act.v_front};

    // Boundary decode of the active timing set
    always_comb begin
        h_last     = act.h_total - X_BITS'(1);
        v_last     = act.v_total - Y_BITS'(1);
        line_end   = (cnt_h == h_last);
        frame_end  = line_end && (cnt_v == v_last);
        h_start    = act.h_sync + act.h_back;
        h_end      = h_start + act.h_disp;
        v_start    = act.v_sync + act.v_back;
        v_end      = v_start + act.v_disp;
        cur_active = (cnt_h >= h_start) && (cnt_h < h_end) &&
                     (cnt_v >= v_start) && (cnt_v < v_end);
    end

    // Position REQ_LEAD cycles ahead; a lookahead past a frame end uses the current set.
    always_comb begin
        h_sum      = cnt_h + X_BITS'(REQ_LEAD);
        ahead_wrap = (h_sum >= act.h_total);
        ah         = ahead_wrap ? (h_sum - act.h_total) : h_sum;
        av         = cnt_v;
        if (ahead_wrap) begin
            av = (cnt_v == v_last) ? '0 : (cnt_v + Y_BITS'(1));
        end
        req_nxt    = (ah >= h_start) && (ah < h_end) &&
                     (av >= v_start) && (av < v_end);
    end

    // Shadow register file write decode
    always_comb begin
        shd_nxt = shd;
        if (cfg_wr) begin
            case (cfg_addr)
                4'd0:    shd_nxt.h_sync  = X_BITS'(cfg_wdata);
                4'd1:    shd_nxt.h_back  = X_BITS'(cfg_wdata);
                4'd2:    shd_nxt.h_disp  = X_BITS'(cfg_wdata);
                4'd3:    shd_nxt.h_front = X_BITS'(cfg_wdata);
                4'd4:    shd_nxt.h_total = X_BITS'(cfg_wdata);
                4'd5:    shd_nxt.v_sync  = Y_BITS'(cfg_wdata);
                4'd6:    shd_nxt.v_back  = Y_BITS'(cfg_wdata);
                4'd7:    shd_nxt.v_disp  = Y_BITS'(cfg_wdata);
                4'd8:    shd_nxt.v_front = Y_BITS'(cfg_wdata);
                4'd9:    shd_nxt.v_total = Y_BITS'(cfg_wdata);
                default: shd_nxt = shd;
            endcase
        end
    end

    // Apply handshake: a request waits for the last cycle of the frame
    always_comb begin
        cfg_state_nxt = cfg_state;
        commit        = 1'b0;
        case (cfg_state)
            CFG_IDLE: begin
                if (cfg_apply) begin
                    cfg_state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (frame_end) begin
                    commit        = 1'b1;
                    cfg_state_nxt = CFG_IDLE;
                end
            end
            default: cfg_state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state <= CFG_IDLE;
            shd       <= TIMING_RST;
            act       <= TIMING_RST;
        end else begin
            cfg_state <= cfg_state_nxt;
            shd       <= shd_nxt;
            if (commit) begin
                act <= shd;
            end
        end
    end

    assign cfg_busy = (cfg_state == CFG_PEND);

    // Raster counters
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (line_end) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == v_last) ? '0 : (cnt_v + Y_BITS'(1));
        end else begin
            cnt_h <= cnt_h + X_BITS'(1);
        end
    end

    // Registered video and request outputs
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            frame_start <= 1'b0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            video_hs    <= (cnt_h < act.h_sync) ? HS_POL : ~HS_POL;
            video_vs    <= (cnt_v < act.v_sync) ? VS_POL : ~VS_POL;
            video_de    <= cur_active;
            frame_start <= cur_active && (cnt_h == h_start) && (cnt_v == v_start);
            pix_req     <= req_nxt;
            pix_x       <= req_nxt ? (ah - h_start) : '0;
            pix_y       <= req_nxt ? (av - v_start) : '0;
        end
    end

`ifdef VTG_PATTERN_EN
    logic [X_BITS-1:0] bar_w;
    logic [X_BITS-1:0] bar_pos;
    logic [2:0]        bar_idx;
    logic [23:0]       bar_rgb;

    assign bar_w = act.h_disp >> 3;

    // Bar index tracks the pixel shown on video_de; the last bar absorbs the remainder.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx <= 3'd0;
            bar_pos <= '0;
        end else if (cur_active) begin
            if (cnt_h == h_start) begin
                bar_idx <= (bar_w == '0) ? 3'd7 : 3'd0;
                bar_pos <= '0;
            end else if ((bar_idx != 3'd7) && (bar_pos == (bar_w - X_BITS'(1)))) begin
                bar_idx <= bar_idx + 3'd1;
                bar_pos <= '0;
            end else begin
                bar_pos <= bar_pos + X_BITS'(1);
            end
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        video_data = 24'd0;
        if (video_de) begin
            video_data = pattern_en ? bar_rgb : pix_data;
        end
    end
`else
    logic unused_pattern;
    assign unused_pattern = pattern_en;

    assign video_data = video_de ? pix_data : 24'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small raster (H 2/3/8/2/15, V 1/2/4/1/8).
module tb_video_timing_gen;

    localparam int HT0 = 15;
    localparam int HT1 = 11;

    logic        pix_clk;
    logic        rst_n;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic        cfg_apply;
    logic [23:0] pix_data;
    logic        pattern_en;

    logic        video_hs, video_vs, video_de, frame_start, pix_req, cfg_busy;
    logic [23:0] video_data;
    logic [11:0] pix_x, pix_y;

    logic        n_hs, n_vs, n_de, n_fs, n_req, n_busy;
    logic [23:0] n_data;
    logic [11:0] n_x, n_y;

    int n_checks;
    int n_fail;
    int cyc;

    video_timing_gen #(
        .X_BITS(12), .Y_BITS(12),
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2), .H_TOTAL(15),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .V_TOTAL(8),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1)
    ) u_dut (
        .pix_clk(pix_clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_apply(cfg_apply),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
        .video_data(video_data), .frame_start(frame_start),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .pattern_en(pattern_en), .cfg_busy(cfg_busy)
    );

    video_timing_gen #(
        .X_BITS(12), .Y_BITS(12),
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2), .H_TOTAL(15),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .V_TOTAL(8),
        .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(1)
    ) u_neg (
        .pix_clk(pix_clk), .rst_n(rst_n),
        .cfg_wr(1'b0), .cfg_addr(4'd0), .cfg_wdata(12'd0), .cfg_apply(1'b0),
        .video_hs(n_hs), .video_vs(n_vs), .video_de(n_de),
        .video_data(n_data), .frame_start(n_fs),
        .pix_req(n_req), .pix_x(n_x), .pix_y(n_y),
        .pix_data(pix_data), .pattern_en(1'b0), .cfg_busy(n_busy)
    );

    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    // Expected raster decode for a position p counted from a frame start
    function automatic bit f_act(input int p, input int ht);
        int h;
        int v;
        h = p % ht;
        v = (p / ht) % 8;
        return (h >= 5) && (h < ht - 2) && (v >= 3) && (v < 7);
    endfunction

    function automatic bit f_hs(input int p, input int ht);
        return (p % ht) < 2;
    endfunction

    function automatic bit f_vs(input int p, input int ht);
        return ((p / ht) % 8) < 1;
    endfunction

    function automatic bit f_fs(input int p, input int ht);
        return (p % (ht * 8)) == (3 * ht + 5);
    endfunction

    function automatic int f_px(input int p, input int ht);
        return f_act(p + 1, ht) ? ((p + 1) % ht) - 5 : 0;
    endfunction

    function automatic int f_py(input int p, input int ht);
        return f_act(p + 1, ht) ? (((p + 1) / ht) % 8) - 3 : 0;
    endfunction

    function automatic logic [23:0] f_colour(input int b);
        case (b)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge pix_clk);
        #1;
        cyc      = cyc + 1;
        pix_data = 24'(cyc * 40503 + 17);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cfg_wr     = 1'b0;
        cfg_addr   = 4'd0;
        cfg_wdata  = 12'd0;
        cfg_apply  = 1'b0;
        pattern_en = 1'b0;
        pix_data   = 24'h123456;
        cyc        = 0;
        repeat (3) @(posedge pix_clk);
        #1;
        n_checks++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL reset_de got=%b exp=0", video_de); end
        n_checks++; if (video_hs !== 1'b0) begin n_fail++; $display("FAIL reset_hs got=%b exp=0", video_hs); end
        n_checks++; if (video_vs !== 1'b0) begin n_fail++; $display("FAIL reset_vs got=%b exp=0", video_vs); end
        n_checks++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", pix_req); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", cfg_busy); end
        n_checks++; if (video_data !== 24'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", video_data); end
        n_checks++; if ({pix_x, pix_y} !== 24'd0) begin n_fail++; $display("FAIL reset_xy got=%h exp=0", {pix_x, pix_y}); end
        n_checks++; if (n_hs !== 1'b1) begin n_fail++; $display("FAIL reset_neg_hs got=%b exp=1", n_hs); end
        n_checks++; if (n_vs !== 1'b1) begin n_fail++; $display("FAIL reset_neg_vs got=%b exp=1", n_vs); end
        n_checks++;
        if ({n_de, n_fs, n_req, n_busy, n_data, n_x, n_y} !== 52'd0) begin
            n_fail++; $display("FAIL reset_neg_other got=%h exp=0", {n_de, n_fs, n_req, n_busy, n_data, n_x, n_y});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_timing();
        int p;
        int de_tot, req_tot, fs_tot, hs_tot, first_de, first_req;
        de_tot = 0; req_tot = 0; fs_tot = 0; hs_tot = 0; first_de = -1; first_req = -1;
        for (int i = 0; i < 240; i++) begin
            tick();
            p = cyc - 1;
            if (video_de === 1'b1) begin de_tot++; if (first_de < 0) first_de = cyc; end
            if (pix_req === 1'b1) begin req_tot++; if (first_req < 0) first_req = cyc; end
            if (frame_start === 1'b1) fs_tot++;
            if (video_hs === 1'b1) hs_tot++;
            n_checks++; if (video_de !== f_act(p, HT0)) begin n_fail++; $display("FAIL basic_de cyc=%0d got=%b exp=%b", cyc, video_de, f_act(p, HT0)); end
            n_checks++; if (video_hs !== f_hs(p, HT0)) begin n_fail++; $display("FAIL basic_hs cyc=%0d got=%b exp=%b", cyc, video_hs, f_hs(p, HT0)); end
            n_checks++; if (video_vs !== f_vs(p, HT0)) begin n_fail++; $display("FAIL basic_vs cyc=%0d got=%b exp=%b", cyc, video_vs, f_vs(p, HT0)); end
            n_checks++; if (pix_req !== f_act(p + 1, HT0)) begin n_fail++; $display("FAIL basic_req cyc=%0d got=%b exp=%b", cyc, pix_req, f_act(p + 1, HT0)); end
            n_checks++; if (pix_x !== 12'(f_px(p, HT0))) begin n_fail++; $display("FAIL basic_x cyc=%0d got=%0d exp=%0d", cyc, pix_x, f_px(p, HT0)); end
            n_checks++; if (pix_y !== 12'(f_py(p, HT0))) begin n_fail++; $display("FAIL basic_y cyc=%0d got=%0d exp=%0d", cyc, pix_y, f_py(p, HT0)); end
            n_checks++; if (frame_start !== f_fs(p, HT0)) begin n_fail++; $display("FAIL basic_fs cyc=%0d got=%b exp=%b", cyc, frame_start, f_fs(p, HT0)); end
            n_checks++;
            if (video_data !== (f_act(p, HT0) ? pix_data : 24'd0)) begin
                n_fail++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", cyc, video_data, f_act(p, HT0) ? pix_data : 24'd0);
            end
        end
        n_checks++; if (de_tot != 64) begin n_fail++; $display("FAIL basic_de_total got=%0d exp=64", de_tot); end
        n_checks++; if (req_tot != 64) begin n_fail++; $display("FAIL basic_req_total got=%0d exp=64", req_tot); end
        n_checks++; if (fs_tot != 2) begin n_fail++; $display("FAIL basic_fs_total got=%0d exp=2", fs_tot); end
        n_checks++; if (hs_tot != 32) begin n_fail++; $display("FAIL basic_hs_total got=%0d exp=32", hs_tot); end
        n_checks++; if (first_de != 51) begin n_fail++; $display("FAIL basic_first_de got=%0d exp=51", first_de); end
        n_checks++; if (first_req != 50) begin n_fail++; $display("FAIL basic_first_req got=%0d exp=50", first_req); end
    endtask

    task automatic test_polarity();
        int p;
        int hs_low, vs_low;
        hs_low = 0; vs_low = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            p = cyc - 1;
            if (n_hs === 1'b0) hs_low++;
            if (n_vs === 1'b0) vs_low++;
            n_checks++; if (n_hs !== !f_hs(p, HT0)) begin n_fail++; $display("FAIL pol_hs cyc=%0d got=%b exp=%b", cyc, n_hs, !f_hs(p, HT0)); end
            n_checks++; if (n_vs !== !f_vs(p, HT0)) begin n_fail++; $display("FAIL pol_vs cyc=%0d got=%b exp=%b", cyc, n_vs, !f_vs(p, HT0)); end
            n_checks++; if (n_de !== f_act(p, HT0)) begin n_fail++; $display("FAIL pol_de cyc=%0d got=%b exp=%b", cyc, n_de, f_act(p, HT0)); end
        end
        n_checks++; if (hs_low != 16) begin n_fail++; $display("FAIL pol_hs_low_total got=%0d exp=16", hs_low); end
        n_checks++; if (vs_low != 15) begin n_fail++; $display("FAIL pol_vs_low_total got=%0d exp=15", vs_low); end
    endtask

    task automatic test_pattern();
        int p;
        logic [23:0] exp_data;
        pattern_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            p = cyc - 1;
            exp_data = 24'd0;
            if (f_act(p, HT0)) begin
`ifdef VTG_PATTERN_EN
                exp_data = f_colour((p % HT0) - 5);
`else
                exp_data = pix_data;
`endif
            end
            n_checks++; if (video_data !== exp_data) begin n_fail++; $display("FAIL pattern_data cyc=%0d got=%h exp=%h", cyc, video_data, exp_data); end
            n_checks++; if (pix_req !== f_act(p + 1, HT0)) begin n_fail++; $display("FAIL pattern_req cyc=%0d got=%b exp=%b", cyc, pix_req, f_act(p + 1, HT0)); end
        end
        pattern_en = 1'b0;
    endtask

    task automatic test_cfg_apply();
        int base, p, de_tot, fs_tot, fs_at;
        logic exp_busy;
        base = cyc;
        for (int i = 0; i < 120; i++) begin
            tick();
            p = cyc - 1;
            exp_busy = (cyc >= base + 13) && (cyc <= base + 119);
            n_checks++; if (video_de !== f_act(p, HT0)) begin n_fail++; $display("FAIL cfg_old_de cyc=%0d got=%b exp=%b", cyc, video_de, f_act(p, HT0)); end
            n_checks++; if (video_hs !== f_hs(p, HT0)) begin n_fail++; $display("FAIL cfg_old_hs cyc=%0d got=%b exp=%b", cyc, video_hs, f_hs(p, HT0)); end
            n_checks++; if (cfg_busy !== exp_busy) begin n_fail++; $display("FAIL cfg_busy cyc=%0d got=%b exp=%b", cyc, cfg_busy, exp_busy); end
            cfg_wr    = 1'b0;
            cfg_apply = 1'b0;
            case (cyc - base)
                10: begin cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_wdata = 12'd4;  end
                11: begin cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 12'd11; end
                12: cfg_apply = 1'b1;
                20: begin cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 12'd13; end
                21: begin cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 12'd11; end
                22: cfg_apply = 1'b1;
                30: begin cfg_wr = 1'b1; cfg_addr = 4'd12; cfg_wdata = 12'd99; end
                default: ;
            endcase
        end
        de_tot = 0; fs_tot = 0; fs_at = -1;
        for (int i = 0; i < 88; i++) begin
            tick();
            p = cyc - (base + 121);
            if (video_de === 1'b1) de_tot++;
            if (frame_start === 1'b1) begin fs_tot++; fs_at = p; end
            n_checks++; if (video_de !== f_act(p, HT1)) begin n_fail++; $display("FAIL cfg_new_de p=%0d got=%b exp=%b", p, video_de, f_act(p, HT1)); end
            n_checks++; if (video_hs !== f_hs(p, HT1)) begin n_fail++; $display("FAIL cfg_new_hs p=%0d got=%b exp=%b", p, video_hs, f_hs(p, HT1)); end
            n_checks++; if (pix_req !== f_act(p + 1, HT1)) begin n_fail++; $display("FAIL cfg_new_req p=%0d got=%b exp=%b", p, pix_req, f_act(p + 1, HT1)); end
            n_checks++; if (pix_x !== 12'(f_px(p, HT1))) begin n_fail++; $display("FAIL cfg_new_x p=%0d got=%0d exp=%0d", p, pix_x, f_px(p, HT1)); end
            n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL cfg_new_busy p=%0d got=%b exp=0", p, cfg_busy); end
        end
        n_checks++; if (de_tot != 16) begin n_fail++; $display("FAIL cfg_new_de_total got=%0d exp=16", de_tot); end
        n_checks++; if (fs_tot != 1) begin n_fail++; $display("FAIL cfg_new_fs_total got=%0d exp=1", fs_tot); end
        n_checks++; if (fs_at != 38) begin n_fail++; $display("FAIL cfg_new_fs_pos got=%0d exp=38", fs_at); end
    endtask

    task automatic test_reset_mid_frame();
        int p;
        tick();
        cfg_wr = 1'b1; cfg_addr = 4'd4; cfg_wdata = 12'd13;
        tick();
        cfg_wr = 1'b0; cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
        tick();
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", cfg_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL rst_mid_de got=%b exp=0", video_de); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", cfg_busy); end
        n_checks++; if ({video_hs, video_vs} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_sync got=%b exp=00", {video_hs, video_vs}); end
        n_checks++; if ({pix_req, frame_start} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_req_fs got=%b exp=00", {pix_req, frame_start}); end
        n_checks++; if (video_data !== 24'd0) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=0", video_data); end
        repeat (2) @(posedge pix_clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 240; i++) begin
            tick();
            p = cyc - 1;
            n_checks++; if (video_de !== f_act(p, HT0)) begin n_fail++; $display("FAIL rst_resume_de cyc=%0d got=%b exp=%b", cyc, video_de, f_act(p, HT0)); end
            n_checks++; if (video_hs !== f_hs(p, HT0)) begin n_fail++; $display("FAIL rst_resume_hs cyc=%0d got=%b exp=%b", cyc, video_hs, f_hs(p, HT0)); end
            n_checks++; if (frame_start !== f_fs(p, HT0)) begin n_fail++; $display("FAIL rst_resume_fs cyc=%0d got=%b exp=%b", cyc, frame_start, f_fs(p, HT0)); end
            n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_resume_busy cyc=%0d got=%b exp=0", cyc, cfg_busy); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_timing();
        test_polarity();
        test_pattern();
        test_cfg_apply();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): X_BITS, 12, horizontal counter/coordinate width; Y_BITS, 12, vertical width.
REQ-002 SHALL have timing parameters H_SYNC 44, H_BACK 148, H_DISP 1920, H_FRONT 88, H_TOTAL 2200, V_SYNC 5, V_BACK 36, V_DISP 1080, V_FRONT 4, V_TOTAL 1125; these are the reset values of the active timing set.
REQ-003 SHALL have HS_POL, 1, hsync active level; VS_POL, 1, vsync active level; REQ_LEAD, 1, cycles pix_req leads video_de (legal 1..4).
REQ-004 SHALL have ports: pix_clk in 1, pixel clock; rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: cfg_wr in 1, shadow write strobe; cfg_addr in 4, field select; cfg_wdata in 12, field value; cfg_apply in 1, request to commit shadow set.
REQ-006 SHALL have ports: video_hs out 1; video_vs out 1; video_de out 1; video_data out 24; frame_start out 1, one-cycle pulse at first pixel of frame.
REQ-007 SHALL have ports: pix_req out 1; pix_x out X_BITS; pix_y out Y_BITS; pix_data in 24; pattern_en in 1; cfg_busy out 1, apply pending.

Function
REQ-008 cnt_h SHALL count 0..h_total-1 then wrap to 0; cnt_v SHALL increment when cnt_h==h_total-1 and wrap to 0 after v_total-1.
REQ-009 hs SHALL be active (HS_POL level) for cnt_h<h_sync; vs active (VS_POL) for cnt_v<v_sync; otherwise inverse level.
REQ-010 active region SHALL be cnt_h in [h_sync+h_back, h_sync+h_back+h_disp) AND cnt_v in [v_sync+v_back, v_sync+v_back+v_disp).
REQ-011 video_hs, video_vs, video_de SHALL be registered: they reflect the counter decode of the previous cycle (1-cycle latency), mutually aligned.
REQ-012 pix_req SHALL be asserted exactly REQ_LEAD cycles before each video_de-high cycle, same count of cycles per line (h_disp).
REQ-013 pix_x/pix_y SHALL give the 0-based coordinate of the pixel requested while pix_req=1, and 0 when pix_req=0.
REQ-014 pix_data SHALL be sampled in the cycle video_de=1; video_data SHALL equal pix_data when video_de=1, else 24'd0 (combinational pass).
REQ-015 frame_start SHALL pulse with the first video_de of each frame (pixel 0,0).
REQ-016 cfg_wr SHALL write cfg_wdata into shadow field cfg_addr: 0 h_sync,1 h_back,2 h_disp,3 h_front,4 h_total,5 v_sync,6 v_back,7 v_disp,8 v_front,9 v_total; addresses 10..15 ignored.
REQ-017 cfg_apply SHALL set cfg_busy; shadow set SHALL copy to active set on the cycle cnt_h==h_total-1 and cnt_v==v_total-1, counters restart at 0,0 with new set, cfg_busy clears same edge.
REQ-018 cfg_wr during cfg_busy SHALL update shadow; last write before the commit edge wins; cfg_apply while busy SHALL be absorbed (single commit).
REQ-019 active timing SHALL never change mid-frame; shadow consistency (sums <= totals) is the writer's responsibility, no checking.
REQ-020 Unsigned arithmetic; boundary sums computed at X_BITS/Y_BITS width, wider intermediates not required.

Reset
REQ-021 On rst_n low: cnt_h=cnt_v=0, active and shadow sets = parameters, cfg_busy=0, video_de=0, frame_start=0, pix_req=0, video_data=0, video_hs/video_vs at inactive level.
REQ-022 Reset mid-frame SHALL abort frame and discard pending apply; first frame after release starts at cnt 0,0.

Configuration
REQ-023 Macro VTG_PATTERN_EN: defined -> pattern_en=1 replaces video_data during video_de with 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), bar width h_disp>>3, last bar absorbs remainder; pix_req still generated.
REQ-024 VTG_PATTERN_EN undefined -> pattern_en port present but ignored, no pattern logic synthesised.

Verification (H 2/3/8/2/15, V 1/2/4/1/8, REQ_LEAD=1, POL=1)
REQ-025 Release reset -> video_de first high one cycle after cnt_h=5,cnt_v=3; 8 de cycles per line, 4 lines/frame, frame period 120 cycles.
REQ-026 Same run -> pix_req high exactly 1 cycle before each de; pix_x 0..7, pix_y 0..3; frame_start one pulse per 120 cycles.
REQ-027 cfg_wr addr2=4, addr4=11, cfg_apply mid-frame -> current frame unchanged, cfg_busy high until frame end, next frame 4 de per line, line period 11.
REQ-028 HS_POL=0,VS_POL=0 -> video_hs low cycles cnt_h 0..1, video_vs low on line 0, high otherwise.
REQ-029 rst_n low mid-line with apply pending -> outputs to reset values, cfg_busy=0, parameter timing resumes.
REQ-030 VTG_PATTERN_EN, pattern_en=1, H_DISP=16 -> de pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000.
